// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with valid/ready handshake and V/Z/N flags.
// Define ALU_SEQ_MUL_EN to add the iterative shift-add multiplier (op 9).
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] src0,
   input  logic [WIDTH-1:0] src1,
   input  logic [SHW-1:0]   shamt,
   input  logic [2:0]       flag_we,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dst,
   output logic [2:0]       flags
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_NOR = 4'd3;
   localparam logic [3:0] OP_SLL = 4'd4;
   localparam logic [3:0] OP_SRL = 4'd5;
   localparam logic [3:0] OP_SRA = 4'd6;
   localparam logic [3:0] OP_LHB = 4'd7;
   localparam logic [3:0] OP_NOP = 4'd8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OUT  = 2'd1;

   localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nx;
   logic [WIDTH-1:0] r_dst;
   logic [2:0]       r_flags;
   logic             w_free;
   logic             w_accept;
   logic             w_mul_op;
   logic             w_mul_done;
   logic             w_cap;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_cap_res;
   logic             w_ovf;
   logic             w_v;
   logic             w_cap_v;
   logic [2:0]       w_we;
   logic [2:0]       w_cap_we;
   logic [2:0]       w_fnew;

   // SUB adds the two's-complement negation; overflow judged on that operand
   assign w_b   = (op == OP_SUB) ? (~src1 + W_ONE) : src1;
   assign w_sum = src0 + w_b;
   assign w_ovf = (src0[WIDTH-1] == w_b[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != src0[WIDTH-1]);

   always_comb begin
      w_res = '0;
      w_v   = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            w_v   = w_ovf;
            w_res = w_ovf ? (src0[WIDTH-1] ? W_MIN : W_MAX) : w_sum;
         end
         OP_AND:  w_res = src0 & src1;
         OP_NOR:  w_res = ~(src0 | src1);
         OP_SLL:  w_res = src0 << shamt;
         OP_SRL:  w_res = src0 >> shamt;
         OP_SRA:  w_res = $signed(src0) >>> shamt;
         OP_LHB:  w_res = {src1[WIDTH/2-1:0], src0[WIDTH/2-1:0]};
         OP_NOP:  w_res = src0;
         default: w_res = '0;
      endcase
   end

   assign w_we     = (op == OP_NOP) ? 3'b000 : flag_we;
   assign w_free   = (r_state != S_OUT) || out_ready;
   assign w_accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0]     OP_MUL   = 4'd9;
   localparam logic [1:0]     S_MUL    = 2'd2;
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_prod;
   logic [2*WIDTH-1:0] w_prod_nx;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   w_mres;
   logic [SHW-1:0]     r_cnt;
   logic [2:0]         r_mwe;
   logic               w_mv;

   assign w_mul_op   = (op == OP_MUL);
   assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_LAST);
   assign in_ready   = (r_state != S_MUL) && w_free;
   assign w_prod_nx  = r_prod + (r_mplier[0] ? r_mcand : '0);
   assign w_mv       = |w_prod_nx[2*WIDTH-1:WIDTH];
   assign w_mres     = w_mv ? '1 : w_prod_nx[WIDTH-1:0];
   assign w_cap_res  = w_mul_done ? w_mres : w_res;
   assign w_cap_v    = w_mul_done ? w_mv : w_v;
   assign w_cap_we   = w_mul_done ? r_mwe : w_we;

   // one partial product per cycle; the last one is folded in at capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_prod   <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_mwe    <= '0;
      end else if (w_accept && w_mul_op) begin
         r_mcand  <= {{WIDTH{1'b0}}, src0};
         r_prod   <= '0;
         r_mplier <= src1;
         r_cnt    <= '0;
         r_mwe    <= flag_we;
      end else if (r_state == S_MUL) begin
         r_mcand  <= r_mcand << 1;
         r_prod   <= w_prod_nx;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + SHW'(1);
      end
   end
`else
   assign w_mul_op   = 1'b0;
   assign w_mul_done = 1'b0;
   assign in_ready   = w_free;
   assign w_cap_res  = w_res;
   assign w_cap_v    = w_v;
   assign w_cap_we   = w_we;
`endif

   assign w_cap  = (w_accept && !w_mul_op) || w_mul_done;
   assign w_fnew = {w_cap_v, (w_cap_res == '0), w_cap_res[WIDTH-1]};

   always_comb begin
      w_state_nx = r_state;
      if (w_accept)
         w_state_nx = S_OUT;
      else if ((r_state == S_OUT) && out_ready)
         w_state_nx = S_IDLE;
`ifdef ALU_SEQ_MUL_EN
      if (w_accept && w_mul_op)
         w_state_nx = S_MUL;
      else if (w_mul_done)
         w_state_nx = S_OUT;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_dst   <= '0;
         r_flags <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_cap) begin
            r_dst   <= w_cap_res;
            r_flags <= (w_cap_we & w_fnew) | (~w_cap_we & r_flags);
         end
      end
   end

   assign out_valid = (r_state == S_OUT);
   assign dst       = r_dst;
   assign flags     = r_flags;

endmodule
